// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// the NOP used to replace faulted fetches, and AXI response codes.
package ifetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_SLEEP = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [1:0]  AXI_OKAY = 2'b00;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_OKAY);
    endfunction

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding AXI read, stale-fetch drop on
// redirect, WFI sleep. Optional macro IFETCH_BUSERR_EN enables bus-error NOP substitution.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pipe_hold,
    input  logic              redirect,
    input  logic              wfi,
    input  logic              interrupt_pulse,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_stall,
    output logic              sleeping,
    output logic              fetch_err
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] araddr_r;
    logic              arvalid_r;
    logic [DATA_W-1:0] inst_r;
    logic              inst_valid_r;
    logic              drop_r;
    logic              fetch_err_r;
    logic              beat_s;
    logic              launch_s;
    logic              accept_s;
    logic              beat_err_s;
    logic              rready_s;
    logic              fetch_stall_s;
    logic              sleeping_s;

    assign beat_s   = rvalid && rlast;
    assign launch_s = (state_r == ST_IDLE) && (state_nxt_s == ST_ADDR);
    // A beat is kept only if no redirect has made it stale, past or present.
    assign accept_s = (state_r == ST_DATA) && beat_s && !drop_r && !redirect;

`ifdef IFETCH_BUSERR_EN
    assign beat_err_s = resp_is_err(rresp);
`else
    logic rresp_unused_s;
    assign rresp_unused_s = ^rresp;
    assign beat_err_s     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wfi && !interrupt_pulse) begin
                    state_nxt_s = ST_SLEEP;
                end else if (!redirect) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (beat_s && (drop_r || redirect)) begin
                    state_nxt_s = ST_IDLE;
                end else if (beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DONE: begin
                // Leaves on consumption or on redirect (discard).
                if (redirect || !pipe_hold) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SLEEP: begin
                if (interrupt_pulse) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SLEEP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        rready_s      = (state_r == ST_DATA);
        sleeping_s    = (state_r == ST_SLEEP);
        fetch_stall_s = !((state_r == ST_DONE) && !pipe_hold && !redirect);
    end

    // AXI address channel, drop flag, instruction register and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_r     <= {ADDR_W{1'b0}};
            arvalid_r    <= 1'b0;
            drop_r       <= 1'b0;
            inst_r       <= {DATA_W{1'b0}};
            inst_valid_r <= 1'b0;
            fetch_err_r  <= 1'b0;
        end else begin
            if (launch_s) begin
                araddr_r  <= pc;
                arvalid_r <= 1'b1;
            end else if ((state_r == ST_ADDR) && arready) begin
                arvalid_r <= 1'b0;
            end

            case (state_r)
                ST_ADDR: begin
                    if (redirect) begin
                        drop_r <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        drop_r <= 1'b0;
                    end else if (redirect) begin
                        drop_r <= 1'b1;
                    end
                end
                default: drop_r <= 1'b0;
            endcase

            if (accept_s) begin
                inst_r       <= beat_err_s ? DATA_W'(NOP_INSN) : rdata;
                inst_valid_r <= 1'b1;
            end else if ((state_r == ST_DONE) && (state_nxt_s == ST_IDLE)) begin
                inst_valid_r <= 1'b0;
            end

            fetch_err_r <= accept_s && beat_err_s;
        end
    end

    assign araddr      = araddr_r;
    assign arvalid     = arvalid_r;
    assign rready      = rready_s;
    assign inst        = inst_r;
    assign inst_valid  = inst_valid_r;
    assign fetch_stall = fetch_stall_s;
    assign sleeping    = sleeping_s;
`ifdef IFETCH_BUSERR_EN
    assign fetch_err   = fetch_err_r;
`else
    logic fetch_err_unused_s;
    assign fetch_err_unused_s = fetch_err_r;
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected instructions are queued as beats
// are driven and compared when the pipeline consumes them.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pipe_hold;
    logic        redirect;
    logic        wfi;
    logic        interrupt_pulse;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_stall;
    logic        sleeping;
    logic        fetch_err;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [31:0] sb_q[$];

    ifetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pipe_hold(pipe_hold), .redirect(redirect),
        .wfi(wfi), .interrupt_pulse(interrupt_pulse), .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .inst(inst), .inst_valid(inst_valid), .fetch_stall(fetch_stall),
        .sleeping(sleeping), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: settle, score any consumption this cycle, advance past the edge.
    task automatic cycle();
        logic [31:0] exp_d;
        #1;
        if (inst_valid === 1'b1 && !pipe_hold && !redirect) begin
            if (sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                check_val("consumed_inst", {32'd0, inst}, {32'd0, exp_d});
            end else begin
                check_val("spurious_consume", 64'd1, 64'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // From IDLE: launch at address a and advance into DATA.
    task automatic to_data(input logic [31:0] a);
        pc = a;
        cycle();
        wfi = 1'b0;
        interrupt_pulse = 1'b0;
        check_val("launch_arvalid", {63'd0, arvalid}, 64'd1);
        check_val("launch_araddr", {32'd0, araddr}, {32'd0, a});
        arready = 1'b1;
        cycle();
        arready = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input int ar_wait, input int hold);
        logic [31:0] exp_d;
        logic        exp_err;
        pc = a;
        cycle();
        wfi = 1'b0;
        interrupt_pulse = 1'b0;
        check_val("ar_valid", {63'd0, arvalid}, 64'd1);
        check_val("ar_addr", {32'd0, araddr}, {32'd0, a});
        for (int i = 0; i < ar_wait; i++) begin
            cycle();
            check_val("ar_hold_valid", {63'd0, arvalid}, 64'd1);
            check_val("ar_hold_addr", {32'd0, araddr}, {32'd0, a});
        end
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        #1;
        check_val("data_rready", {63'd0, rready}, 64'd1);
        check_val("data_arvalid", {63'd0, arvalid}, 64'd0);
`ifdef IFETCH_BUSERR_EN
        exp_err = (resp != 2'b00);
`else
        exp_err = 1'b0;
`endif
        exp_d = exp_err ? 32'h0000_0013 : d;
        rvalid = 1'b1; rlast = 1'b1; rdata = d; rresp = resp;
        sb_q.push_back(exp_d);
        cycle();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        check_val("done_valid", {63'd0, inst_valid}, 64'd1);
        check_val("done_err", {63'd0, fetch_err}, {63'd0, exp_err});
        if (hold > 0) begin
            pipe_hold = 1'b1;
            for (int i = 0; i < hold; i++) begin
                #1;
                check_val("hold_stall", {63'd0, fetch_stall}, 64'd1);
                check_val("hold_inst", {32'd0, inst}, {32'd0, exp_d});
                check_val("hold_valid", {63'd0, inst_valid}, 64'd1);
                cycle();
            end
            check_val("err_one_cycle", {63'd0, fetch_err}, 64'd0);
            pipe_hold = 1'b0;
        end
        #1;
        check_val("done_stall", {63'd0, fetch_stall}, 64'd0);
        cycle();
        check_val("after_consume_valid", {63'd0, inst_valid}, 64'd0);
        check_val("after_consume_stall", {63'd0, fetch_stall}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = 32'h0; pipe_hold = 1'b0; redirect = 1'b0; wfi = 1'b0;
        interrupt_pulse = 1'b0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_arvalid", {63'd0, arvalid}, 64'd0);
        check_val("rst_araddr", {32'd0, araddr}, 64'd0);
        check_val("rst_rready", {63'd0, rready}, 64'd0);
        check_val("rst_inst", {32'd0, inst}, 64'd0);
        check_val("rst_valid", {63'd0, inst_valid}, 64'd0);
        check_val("rst_stall", {63'd0, fetch_stall}, 64'd1);
        check_val("rst_sleep", {63'd0, sleeping}, 64'd0);
        check_val("rst_err", {63'd0, fetch_err}, 64'd0);
        rst = 1'b0;

        // Zero-wait fetch, then a 5-cycle pipe_hold in DONE.
        do_fetch(32'h0000_0100, 32'h0050_0093, 2'b00, 0, 0);
        do_fetch(32'h0000_0104, 32'h00a0_0113, 2'b00, 0, 5);

        // Redirect in IDLE suppresses the launch for one cycle.
        redirect = 1'b1; pc = 32'h0000_0bad;
        cycle();
        redirect = 1'b0;
        check_val("idle_redirect_arvalid", {63'd0, arvalid}, 64'd0);
        do_fetch(32'h0000_0108, 32'h0010_0193, 2'b00, 0, 0);

        // Delayed arready with redirect in the first ADDR cycle: beat dropped.
        pc = 32'h0000_0200;
        cycle();
        redirect = 1'b1;
        check_val("drop_ar_addr", {32'd0, araddr}, 64'h200);
        cycle();
        redirect = 1'b0; pc = 32'h0000_0300;
        for (int i = 0; i < 2; i++) begin
            check_val("drop_ar_hold", {31'd0, arvalid, araddr}, {31'd0, 1'b1, 32'h200});
            cycle();
        end
        arready = 1'b1;
        cycle();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'hdead_beef;
        cycle();
        rvalid = 1'b0; rlast = 1'b0;
        check_val("drop_no_valid", {63'd0, inst_valid}, 64'd0);
        do_fetch(32'h0000_0300, 32'h0020_0213, 2'b00, 0, 0);

        // Redirect coincident with rvalid in DATA discards the beat.
        to_data(32'h0000_0400);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_1111; redirect = 1'b1;
        cycle();
        rvalid = 1'b0; rlast = 1'b0; redirect = 1'b0;
        check_val("data_redirect_valid", {63'd0, inst_valid}, 64'd0);
        do_fetch(32'h0000_0404, 32'h0030_0293, 2'b00, 1, 0);

        // Redirect together with pipe_hold in DONE discards the instruction.
        to_data(32'h0000_0408);
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h2222_2222;
        cycle();
        rvalid = 1'b0; rlast = 1'b0;
        check_val("done_redirect_pre", {63'd0, inst_valid}, 64'd1);
        pipe_hold = 1'b1; redirect = 1'b1;
        #1;
        check_val("done_redirect_stall", {63'd0, fetch_stall}, 64'd1);
        cycle();
        pipe_hold = 1'b0; redirect = 1'b0;
        check_val("done_redirect_valid", {63'd0, inst_valid}, 64'd0);

        // WFI: sleep 10 cycles, then wake on interrupt and fetch the vector.
        wfi = 1'b1;
        cycle();
        wfi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("sleep_state", {61'd0, sleeping, arvalid, fetch_stall}, {61'd0, 3'b101});
            cycle();
        end
        interrupt_pulse = 1'b1;
        cycle();
        interrupt_pulse = 1'b0;
        check_val("wake_sleeping", {63'd0, sleeping}, 64'd0);
        check_val("wake_arvalid", {63'd0, arvalid}, 64'd0);
        do_fetch(32'h0000_001c, 32'h3420_2373, 2'b00, 0, 0);

        // wfi with interrupt_pulse in IDLE: no sleep, fetch launches.
        wfi = 1'b1; interrupt_pulse = 1'b1;
        do_fetch(32'h0000_0020, 32'h0040_0313, 2'b00, 0, 0);
        check_val("wfi_int_no_sleep", {63'd0, sleeping}, 64'd0);

        // Bus error response: NOP substitution and one-cycle error pulse when enabled.
        do_fetch(32'h0000_0120, 32'hffff_ffff, 2'b10, 1, 2);
        do_fetch(32'h0000_0124, 32'h0050_0393, 2'b00, 0, 0);

        // Asynchronous reset while in DATA.
        to_data(32'h0000_0500);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_arvalid", {63'd0, arvalid}, 64'd0);
        check_val("arst_rready", {63'd0, rready}, 64'd0);
        check_val("arst_valid", {63'd0, inst_valid}, 64'd0);
        check_val("arst_inst", {32'd0, inst}, 64'd0);
        check_val("arst_stall", {63'd0, fetch_stall}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        do_fetch(32'h0000_0600, 32'h0060_0413, 2'b00, 0, 0);

        check_val("scoreboard_empty", {32'd0, 32'(sb_q.size())}, 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
